// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared constants, sample type and index helper for the FFT output
//   serializer slice.
//   N       : bins per FFT frame
//   LANES   : bins carried per output beat
//   BEATS   : beats per frame (N / LANES)
//   IDX_W   : bin index width
//   bitrev9 : 9-bit bit reversal used for bit-reversed read-out order
// -----------------------------------------------------------------------------
package fft_pkg;

   localparam int N        = 512;
   localparam int LANES    = 16;
   localparam int BEATS    = 32;
   localparam int IDX_W    = 9;
   localparam int BEAT_W   = 5;
   localparam int LANE_W   = 4;
   localparam int SAMPLE_W = 13;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   function automatic logic [IDX_W-1:0] bitrev9(input logic [IDX_W-1:0] x);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < IDX_W; i++) begin
         r[i] = x[IDX_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_out_serializer_bank.sv
// -----------------------------------------------------------------------------
// fft_frame_bank
//   One frame store of N complex samples.
//   clk      : clock
//   we_i     : capture wr_re_i/wr_im_i (all N bins) at this edge
//   wr_re_i  : N signed real bins
//   wr_im_i  : N signed imag bins
//   beat_i   : beat to present on the read port
//   rd_re_o  : LANES signed real samples of beat_i (combinational)
//   rd_im_o  : LANES signed imag samples of beat_i (combinational)
//   Lane l of beat b is bin j = 16*b + l, sourced from bitrev9(j) when
//   BIT_REVERSE is set. Storage is not reset; validity lives in the top level.
// -----------------------------------------------------------------------------
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int WIDTH       = 13,
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic                    clk,
   input  logic                    we_i,
   input  logic signed [WIDTH-1:0] wr_re_i [N],
   input  logic signed [WIDTH-1:0] wr_im_i [N],
   input  logic [BEAT_W-1:0]       beat_i,
   output logic signed [WIDTH-1:0] rd_re_o [LANES],
   output logic signed [WIDTH-1:0] rd_im_o [LANES]
);

   logic signed [WIDTH-1:0] mem_re_q [N];
   logic signed [WIDTH-1:0] mem_im_q [N];

   function automatic logic [IDX_W-1:0] src_idx(input logic [BEAT_W-1:0] b,
                                                input logic [LANE_W-1:0] l);
      logic [IDX_W-1:0] j;
      j = {b, l};
      return BIT_REVERSE ? bitrev9(j) : j;
   endfunction

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_re_q <= wr_re_i;
         mem_im_q <= wr_im_i;
      end
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         rd_re_o[l] = mem_re_q[src_idx(beat_i, LANE_W'(l))];
         rd_im_o[l] = mem_im_q[src_idx(beat_i, LANE_W'(l))];
      end
   end

endmodule

// File: rtl/fft_out_serializer.sv
// -----------------------------------------------------------------------------
// fft_out_serializer
//   Captures 512-bin FFT frames into a ping-pong bank pair and streams each
//   frame as 32 beats of 16 complex lanes over valid/ready.
//   clk, rst            : clock, asynchronous active-high reset
//   din_re/din_im/din_en: parallel frame input, sampled when din_en=1
//   dout_re/dout_im     : registered lanes of the current beat
//   dout_valid/ready    : beat handshake
//   dout_beat           : beat number 0..31; dout_first/dout_last mark ends
//   ovf / ovf_sticky    : frame-dropped pulse and its sticky flag
// -----------------------------------------------------------------------------
module fft_out_serializer
   import fft_pkg::*;
#(
   parameter int WIDTH       = 13,
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] din_re [N],
   input  logic signed [WIDTH-1:0] din_im [N],
   input  logic                    din_en,
   output logic signed [WIDTH-1:0] dout_re [LANES],
   output logic signed [WIDTH-1:0] dout_im [LANES],
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic [BEAT_W-1:0]       dout_beat,
   output logic                    dout_first,
   output logic                    dout_last,
   output logic                    ovf,
   output logic                    ovf_sticky
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS-1);

   logic [1:0]        full_q, full_d;
   logic              wptr_q, wptr_d;
   // ld_* tracks the next beat to copy into the output register; out_bank
   // remembers which bank the beat now in the output register came from.
   logic              ld_ptr_q, ld_ptr_d;
   logic [BEAT_W-1:0] ld_beat_q, ld_beat_d;
   logic              out_bank_q, out_bank_d;
   logic [BEAT_W-1:0] beat_out_q, beat_out_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic              sticky_q, sticky_d;

   logic signed [WIDTH-1:0] out_re_q [LANES];
   logic signed [WIDTH-1:0] out_im_q [LANES];
   logic signed [WIDTH-1:0] rd_re0 [LANES];
   logic signed [WIDTH-1:0] rd_im0 [LANES];
   logic signed [WIDTH-1:0] rd_re1 [LANES];
   logic signed [WIDTH-1:0] rd_im1 [LANES];

   logic xfer, free_now, accept, ld_en;

   assign xfer     = valid_q & dout_ready;
   // The bank is released only when its final beat leaves the output register.
   assign free_now = xfer & (beat_out_q == LAST_BEAT);
   // With both banks full, the bank being freed is always the oldest one,
   // which is also where the write pointer sits.
   assign accept   = din_en & (~full_q[wptr_q] | (free_now & (out_bank_q == wptr_q)));
   assign ld_en    = full_q[ld_ptr_q] & (~valid_q | dout_ready);

   fft_frame_bank #(.WIDTH(WIDTH), .BIT_REVERSE(BIT_REVERSE)) u_bank0 (
      .clk     (clk),
      .we_i    (accept & ~wptr_q),
      .wr_re_i (din_re),
      .wr_im_i (din_im),
      .beat_i  (ld_beat_q),
      .rd_re_o (rd_re0),
      .rd_im_o (rd_im0)
   );

   fft_frame_bank #(.WIDTH(WIDTH), .BIT_REVERSE(BIT_REVERSE)) u_bank1 (
      .clk     (clk),
      .we_i    (accept & wptr_q),
      .wr_re_i (din_re),
      .wr_im_i (din_im),
      .beat_i  (ld_beat_q),
      .rd_re_o (rd_re1),
      .rd_im_o (rd_im1)
   );

   always_comb begin
      full_d     = full_q;
      wptr_d     = wptr_q;
      ld_ptr_d   = ld_ptr_q;
      ld_beat_d  = ld_beat_q;
      out_bank_d = out_bank_q;
      beat_out_d = beat_out_q;
      valid_d    = valid_q;
      if (free_now) begin
         full_d[out_bank_q] = 1'b0;
      end
      // Set after clear so a bank freed and refilled on one edge stays full.
      if (accept) begin
         full_d[wptr_q] = 1'b1;
         wptr_d         = ~wptr_q;
      end
      if (ld_en) begin
         out_bank_d = ld_ptr_q;
         beat_out_d = ld_beat_q;
         ld_beat_d  = ld_beat_q + 1'b1;
         valid_d    = 1'b1;
         if (ld_beat_q == LAST_BEAT) begin
            ld_ptr_d = ~ld_ptr_q;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
      ovf_d    = din_en & ~accept;
      sticky_d = sticky_q | ovf_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q     <= '0;
         wptr_q     <= 1'b0;
         ld_ptr_q   <= 1'b0;
         ld_beat_q  <= '0;
         out_bank_q <= 1'b0;
         beat_out_q <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         full_q     <= full_d;
         wptr_q     <= wptr_d;
         ld_ptr_q   <= ld_ptr_d;
         ld_beat_q  <= ld_beat_d;
         out_bank_q <= out_bank_d;
         beat_out_q <= beat_out_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         sticky_q   <= sticky_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int l = 0; l < LANES; l++) begin
            out_re_q[l] <= '0;
            out_im_q[l] <= '0;
         end
      end else if (ld_en) begin
         for (int l = 0; l < LANES; l++) begin
            out_re_q[l] <= ld_ptr_q ? rd_re1[l] : rd_re0[l];
            out_im_q[l] <= ld_ptr_q ? rd_im1[l] : rd_im0[l];
         end
      end
   end

   assign dout_re    = out_re_q;
   assign dout_im    = out_im_q;
   assign dout_valid = valid_q;
   assign dout_beat  = beat_out_q;
   assign dout_first = valid_q & (beat_out_q == '0);
   assign dout_last  = valid_q & (beat_out_q == LAST_BEAT);
   assign ovf        = ovf_q;
   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_fft_out_serializer
//   Directed bench driving two serializers (natural and bit-reversed order)
//   from the same frame input and handshake.
// -----------------------------------------------------------------------------
module tb_fft_out_serializer;

   localparam int W = 13;

   logic clk = 1'b0;
   logic rst;
   logic signed [W-1:0] din_re [512];
   logic signed [W-1:0] din_im [512];
   logic din_en;
   logic dout_ready;

   logic signed [W-1:0] d0_re [16];
   logic signed [W-1:0] d0_im [16];
   logic d0_valid, d0_first, d0_last, d0_ovf, d0_sticky;
   logic [4:0] d0_beat;
   logic signed [W-1:0] d1_re [16];
   logic signed [W-1:0] d1_im [16];
   logic d1_valid, d1_first, d1_last, d1_ovf, d1_sticky;
   logic [4:0] d1_beat;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fft_out_serializer #(.WIDTH(W), .BIT_REVERSE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .din_re(din_re), .din_im(din_im), .din_en(din_en),
      .dout_re(d0_re), .dout_im(d0_im), .dout_valid(d0_valid), .dout_ready(dout_ready),
      .dout_beat(d0_beat), .dout_first(d0_first), .dout_last(d0_last),
      .ovf(d0_ovf), .ovf_sticky(d0_sticky)
   );

   fft_out_serializer #(.WIDTH(W), .BIT_REVERSE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .din_re(din_re), .din_im(din_im), .din_en(din_en),
      .dout_re(d1_re), .dout_im(d1_im), .dout_valid(d1_valid), .dout_ready(dout_ready),
      .dout_beat(d1_beat), .dout_first(d1_first), .dout_last(d1_last),
      .ovf(d1_ovf), .ovf_sticky(d1_sticky)
   );

   function automatic int brev(input int j);
      int r;
      r = 0;
      for (int i = 0; i < 9; i++) if (((j >> i) & 1) != 0) r = r | (1 << (8 - i));
      return r;
   endfunction

   // Frame tag in the top bits makes every frame distinguishable.
   function automatic int exp_re(input int tag, input int k);
      return (tag << 9) | k;
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input int tag);
      for (int k = 0; k < 512; k++) begin
         din_re[k] = W'(exp_re(tag, k));
         din_im[k] = W'(-exp_re(tag, k));
      end
   endtask

   task automatic pulse(input int tag);
      set_frame(tag);
      din_en = 1'b1;
      tick();
      din_en = 1'b0;
   endtask

   task automatic check_beat(input string t, input int ftag, input int b);
      chk($sformatf("%s b%0d valid0", t, b), d0_valid, 1);
      chk($sformatf("%s b%0d valid1", t, b), d1_valid, 1);
      chk($sformatf("%s b%0d beat0", t, b), d0_beat, b);
      chk($sformatf("%s b%0d beat1", t, b), d1_beat, b);
      chk($sformatf("%s b%0d first", t, b), d0_first, (b == 0) ? 1 : 0);
      chk($sformatf("%s b%0d last", t, b), d0_last, (b == 31) ? 1 : 0);
      chk($sformatf("%s b%0d last1", t, b), d1_last, (b == 31) ? 1 : 0);
      for (int l = 0; l < 16; l++) begin
         chk($sformatf("%s b%0d l%0d re0", t, b, l), d0_re[l], exp_re(ftag, 16*b+l));
         chk($sformatf("%s b%0d l%0d im0", t, b, l), d0_im[l], -exp_re(ftag, 16*b+l));
         chk($sformatf("%s b%0d l%0d re1", t, b, l), d1_re[l], exp_re(ftag, brev(16*b+l)));
         chk($sformatf("%s b%0d l%0d im1", t, b, l), d1_im[l], -exp_re(ftag, brev(16*b+l)));
      end
   endtask

   task automatic stream(input string t, input int ftag, input int b0, input int b1);
      for (int b = b0; b <= b1; b++) begin
         check_beat(t, ftag, b);
         tick();
      end
   endtask

   initial begin
      rst        = 1'b1;
      din_en     = 1'b0;
      dout_ready = 1'b1;
      set_frame(0);
      tick(); tick(); tick();
      chk("reset valid", d0_valid, 0);
      chk("reset beat", d0_beat, 0);
      chk("reset first", d0_first, 0);
      chk("reset re0", d0_re[0], 0);
      chk("reset ovf", d0_ovf, 0);
      chk("reset sticky", d0_sticky, 0);
      rst = 1'b0;
      tick(); tick();

      // Natural and bit-reversed order, 2-cycle latency, 32 back-to-back beats
      pulse(0);
      chk("t1 latency valid", d0_valid, 0);
      tick();
      chk("t2 b0 l1", d1_re[1], 256);
      chk("t2 b0 l2", d1_re[2], 128);
      chk("t2 b0 l3", d1_re[3], 384);
      chk("t2 b0 l4", d1_re[4], 64);
      stream("t1", 0, 0, 30);
      chk("t2 b31 l15", d1_re[15], 511);
      stream("t1", 0, 31, 31);
      chk("t1 end valid", d0_valid, 0);
      chk("t1 end valid1", d1_valid, 0);

      // Back-pressure hold on beat 5
      pulse(1);
      tick();
      stream("t3", 1, 0, 4);
      dout_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_beat("t3 hold", 1, 5);
         tick();
      end
      dout_ready = 1'b1;
      stream("t3", 1, 5, 31);
      chk("t3 end valid", d0_valid, 0);
      chk("t3 sticky", d0_sticky, 0);

      // Three frames back to back with ready low: third is dropped
      dout_ready = 1'b0;
      set_frame(2);
      din_en = 1'b1;
      tick();
      set_frame(3);
      tick();
      chk("t4 ovf after B", d0_ovf, 0);
      set_frame(4);
      tick();
      din_en = 1'b0;
      chk("t4 ovf pulse", d0_ovf, 1);
      chk("t4 ovf pulse1", d1_ovf, 1);
      chk("t4 sticky", d0_sticky, 1);
      tick();
      chk("t4 ovf cleared", d0_ovf, 0);
      chk("t4 sticky held", d0_sticky, 1);
      chk("t4 sticky held1", d1_sticky, 1);
      check_beat("t4 A wait", 2, 0);
      dout_ready = 1'b1;
      stream("t4 A", 2, 0, 31);
      stream("t4 B", 3, 0, 31);
      chk("t4 end valid", d0_valid, 0);

      // Frame arrives on the same edge the last beat frees a bank
      dout_ready = 1'b0;
      set_frame(5);
      din_en = 1'b1;
      tick();
      set_frame(6);
      tick();
      din_en = 1'b0;
      dout_ready = 1'b1;
      stream("t5 X", 5, 0, 30);
      set_frame(7);
      din_en = 1'b1;
      check_beat("t5 X", 5, 31);
      tick();
      din_en = 1'b0;
      chk("t5 no ovf", d0_ovf, 0);
      chk("t5 no ovf1", d1_ovf, 0);
      stream("t5 Y", 6, 0, 31);
      stream("t5 Z", 7, 0, 31);
      chk("t5 end valid", d0_valid, 0);

      // Asynchronous reset in the middle of a frame
      pulse(1);
      tick();
      stream("t6 pre", 1, 0, 9);
      rst = 1'b1;
      #1;
      chk("t6 rst valid", d0_valid, 0);
      chk("t6 rst valid1", d1_valid, 0);
      chk("t6 rst beat", d0_beat, 0);
      chk("t6 rst re0", d0_re[0], 0);
      chk("t6 rst im3", d0_im[3], 0);
      chk("t6 rst sticky", d0_sticky, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6 post valid", d0_valid, 0);
      pulse(3);
      chk("t6 latency valid", d0_valid, 0);
      tick();
      stream("t6", 3, 0, 31);
      chk("t6 end valid", d0_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
